// File: rtl/serial_tx.sv
// serial_tx: UART 8N1 transmitter fed by a packet builder, with CTS gating, byte counter and sticky overflow flag.
module serial_tx #(
  parameter int CLKDIV = 104
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  DataVal,
  input  logic        DataReady,
  output logic        DataNext,
  input  logic        DataOverf,
  input  logic        ctsN,
  output logic        TxD,
  output logic        busy,
  output logic        ovfSticky,
  input  logic        ovfClr,
  output logic [15:0] byteCount
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [15:0] RELOAD = 16'(CLKDIV - 1);
  state_t      state, stateNxt;
  logic [7:0]  shiftReg, shiftNxt;
  logic [15:0] baudCnt, baudNxt;
  logic [2:0]  bitIdx, bitNxt;
  logic [15:0] byteCountNxt;
  logic        txdNxt, nextNxt, ovfNxt, bitEnd;
  assign bitEnd = baudCnt == 16'd0;
  always_comb begin
    stateNxt = state;
    shiftNxt = shiftReg;
    baudNxt = (state == IDLE) ? 16'd0 : (bitEnd ? RELOAD : baudCnt - 16'd1);
    bitNxt = bitIdx;
    txdNxt = TxD;
    nextNxt = 1'b0;
    byteCountNxt = byteCount;
    ovfNxt = DataOverf | (ovfSticky & ~ovfClr);
    case (state)
      IDLE: if (DataReady && !ctsN) begin
        stateNxt = START;
        shiftNxt = DataVal;
        txdNxt = 1'b0;
        baudNxt = RELOAD;
        nextNxt = 1'b1;
      end
      START: if (bitEnd) begin
        stateNxt = DATA;
        txdNxt = shiftReg[0];
        bitNxt = 3'd0;
      end
      DATA: if (bitEnd) begin
        bitNxt = bitIdx + 3'd1;
        stateNxt = (bitIdx == 3'd7) ? STOP : DATA;
        txdNxt = (bitIdx == 3'd7) ? 1'b1 : shiftReg[bitIdx + 3'd1];
      end
      STOP: if (bitEnd) begin
        stateNxt = IDLE;
        byteCountNxt = byteCount + 16'd1;
      end
      default: stateNxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      shiftReg <= '0;
      baudCnt <= '0;
      bitIdx <= '0;
      TxD <= 1'b1;
      DataNext <= 1'b0;
      busy <= 1'b0;
      ovfSticky <= 1'b0;
      byteCount <= '0;
    end else begin
      state <= stateNxt;
      shiftReg <= shiftNxt;
      baudCnt <= baudNxt;
      bitIdx <= bitNxt;
      TxD <= txdNxt;
      DataNext <= nextNxt;
      busy <= stateNxt != IDLE;
      ovfSticky <= ovfNxt;
      byteCount <= byteCountNxt;
    end
  end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed frame vectors plus hand-written sequences for back-to-back, CTS, reset, overflow and wrap.
module tb_serial_tx;
  localparam int CLKDIV = 4;
  logic        clk = 0, rst = 1;
  logic [7:0]  DataVal = 0;
  logic        DataReady = 0, DataOverf = 0, ctsN = 1, ovfClr = 0;
  logic        DataNext, TxD, busy, ovfSticky;
  logic [15:0] byteCount;
  int total = 0, passed = 0;

  typedef struct {
    logic [7:0]  d;
    logic [9:0]  frame;
    logic [15:0] cnt;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  serial_tx #(.CLKDIV(CLKDIV)) dut (
    .clk(clk), .rst(rst), .DataVal(DataVal), .DataReady(DataReady), .DataNext(DataNext),
    .DataOverf(DataOverf), .ctsN(ctsN), .TxD(TxD), .busy(busy), .ovfSticky(ovfSticky),
    .ovfClr(ovfClr), .byteCount(byteCount)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic waitFetch(output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (DataNext) begin
        ok = 1;
        break;
      end
    end
  endtask

  // frame is LSB-first: bit 0 is the start bit, bit 9 the stop bit
  task automatic runFrame(input logic [7:0] d, input logic [9:0] frame, input logic [15:0] cnt, input int ctsAt);
    bit ok;
    int pulses;
    DataVal = d;
    DataReady = 1;
    ctsN = 0;
    waitFetch(ok);
    chk("fetch", ok, 1);
    if (ctsAt < 0) DataReady = 0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("txd_bit%0d", i / 4), TxD, frame[i / 4]);
      chk("busy_frame", busy, 1);
      pulses += DataNext;
      if (i == 2) DataVal = ~d;
      if (i == ctsAt) ctsN = 1;
      @(negedge clk);
    end
    chk("one_datanext", pulses, 1);
    chk("busy_end", busy, 0);
    chk("txd_idle", TxD, 1);
    chk("bytecount", byteCount, cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int np, run, bad, pulses;
    int t[3];
    int runs[3];
    vecs[0] = '{8'hA5, 10'h34A, 16'd1};
    vecs[1] = '{8'h00, 10'h200, 16'd2};
    vecs[2] = '{8'hFF, 10'h3FE, 16'd3};
    vecs[3] = '{8'h3C, 10'h278, 16'd4};
    vecs[4] = '{8'h55, 10'h2AA, 16'd5};
    #3 rst = 0;
    DataReady = 1;
    ctsN = 0;
    repeat (3) @(negedge clk);
    chk("rst_txd", TxD, 1);
    chk("rst_busy", busy, 0);
    chk("rst_next", DataNext, 0);
    chk("rst_ovf", ovfSticky, 0);
    chk("rst_count", byteCount, 0);
    DataReady = 0;
    rst = 1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) runFrame(vecs[i].d, vecs[i].frame, vecs[i].cnt, -1);

    // back-to-back bytes with DataReady held high
    DataVal = 8'h55;
    DataReady = 1;
    ctsN = 0;
    np = 0;
    run = 0;
    for (int c = 0; c < 200 && np < 3; c++) begin
      @(negedge clk);
      if (DataNext) begin
        t[np] = c;
        runs[np] = run;
        np++;
        if (np == 3) DataReady = 0;
      end
      run = TxD ? run + 1 : 0;
    end
    chk("b2b_pulses", np, 3);
    chk("b2b_gap1", t[1] - t[0], 41);
    chk("b2b_gap2", t[2] - t[1], 41);
    chk("b2b_high1", runs[1], 5);
    chk("b2b_high2", runs[2], 5);
    repeat (45) @(negedge clk);
    chk("b2b_count", byteCount, 8);
    chk("b2b_busy", busy, 0);

    // ctsN deasserted during data bit 3 must not abort the frame
    runFrame(8'h3C, 10'h278, 16'd9, 17);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (DataNext || !TxD || busy) bad++;
    end
    chk("cts_hold", bad, 0);
    ctsN = 0;
    waitFetch(ok);
    chk("cts_resume", ok, 1);
    DataReady = 0;
    repeat (45) @(negedge clk);
    chk("cts_count", byteCount, 10);

    // asynchronous reset in the middle of DATA
    DataVal = 8'hC3;
    DataReady = 1;
    waitFetch(ok);
    chk("rst_mid_fetch", ok, 1);
    repeat (15) @(negedge clk);
    chk("rst_mid_busy_pre", busy, 1);
    #2 rst = 0;
    #1;
    chk("rst_mid_txd", TxD, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_count", byteCount, 0);
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      pulses += DataNext;
    end
    chk("rst_mid_next", pulses, 0);
    rst = 1;
    @(negedge clk);
    chk("rst_first_fetch", DataNext, 1);
    DataReady = 0;
    repeat (42) @(negedge clk);
    chk("rst_after_count", byteCount, 1);

    // sticky overflow flag
    DataOverf = 1;
    @(negedge clk);
    DataOverf = 0;
    @(negedge clk);
    chk("ovf_set", ovfSticky, 1);
    repeat (3) @(negedge clk);
    chk("ovf_hold", ovfSticky, 1);
    DataOverf = 1;
    ovfClr = 1;
    @(negedge clk);
    DataOverf = 0;
    chk("ovf_both", ovfSticky, 1);
    @(negedge clk);
    ovfClr = 0;
    chk("ovf_clr", ovfSticky, 0);

    // byte counter wrap from 0xFFFF
    force dut.byteCountNxt = 16'hFFFF;
    @(negedge clk);
    release dut.byteCountNxt;
    chk("wrap_preset", byteCount, 16'hFFFF);
    runFrame(8'h81, 10'h302, 16'h0000, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
